// File: rtl/prog_loader_if.sv
// prog_loader_if: write-port bundle from prog_loader to the memory adapters'
// controller-write interfaces.
//   we    : one-hot, single-cycle write strobe per target memory
//   addr  : word address (held between strobes)
//   wdata : write data   (held between strobes)
// Modports: master (loader side, drives), slave (memory adapter side).
interface prog_loader_if #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 12,
  parameter int NumTargets = 2
);
  logic [NumTargets-1:0] we;
  logic [AddrWidth-1:0]  addr;
  logic [DataWidth-1:0]  wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: UART 8N1 receiver feeding a framed loader that writes words
// into one of NumTargets memories and holds the core in reset while
// programming mode is active.
// Frame: TARGET, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN*(DataWidth/8) data
// bytes (little-endian), then an XOR checksum over the data bytes.
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   prog_i         programming-mode level
//   clks_per_bit_i UART bit period in clk_i cycles (clamped to >= 4)
//   rx_i           UART serial input, idle high, asynchronous
//   wr_bus         write port bundle (we / addr / wdata)
//   prog_rst_no    core reset, low while programming
//   done_o         one-cycle pulse when a frame ends with a good checksum
//   err_o          sticky error flag, cleared by the next accepted target
//   err_code_o     last error: 0 framing, 1 bad target, 2 checksum, 3 abort
module prog_loader #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 12,
  parameter int NumTargets = 2,
  parameter int CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                prog_i,
  input  logic [CntWidth-1:0] clks_per_bit_i,
  input  logic                rx_i,
  prog_loader_if.master       wr_bus,
  output logic                prog_rst_no,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);
  localparam int NumBytes = DataWidth / 8;
  localparam int IdxWidth = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int TgtWidth = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam int ByteBits = 8;
  localparam logic [IdxWidth-1:0] LastIdx    = IdxWidth'(NumBytes - 1);
  localparam logic [7:0]          NumTgtByte = 8'(NumTargets);
  localparam logic [CntWidth-1:0] MinPeriod  = CntWidth'(3'd4);
  localparam logic [1:0] ErrFraming = 2'd0;
  localparam logic [1:0] ErrTarget  = 2'd1;
  localparam logic [1:0] ErrCsum    = 2'd2;
  localparam logic [1:0] ErrAbort   = 2'd3;

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  rx_state_e           rx_state_q, rx_state_d;
  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntWidth-1:0] rx_cnt_q, rx_cnt_d, rx_period_q, rx_period_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic                rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
  logic                rx_fall_s, rx_half_s, rx_full_s;

  assign rx_fall_s = rx_prev_q & ~rx_sync_q;
  assign rx_half_s = (rx_cnt_q == ({1'b0, rx_period_q[CntWidth-1:1]} - CntWidth'(1'b1)));
  assign rx_full_s = (rx_cnt_q == (rx_period_q - CntWidth'(1'b1)));

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_period_q <= MinPeriod;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_period_q <= rx_period_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_ferr_q   <= rx_ferr_d;
    end
  end

  // Receiver next state; a high line at the half-period start check is a glitch.
  always_comb begin
    rx_state_d = rx_state_q;
    if (!prog_i) begin
      rx_state_d = RxIdle;
    end else begin
      case (rx_state_q)
        RxIdle:  if (rx_fall_s) rx_state_d = RxStart; else rx_state_d = RxIdle;
        RxStart: if (rx_half_s) rx_state_d = rx_sync_q ? RxIdle : RxData;
                 else rx_state_d = RxStart;
        RxData:  if (rx_full_s && (rx_bit_q == 3'd7)) rx_state_d = RxStop;
                 else rx_state_d = RxData;
        RxStop:  if (rx_full_s) rx_state_d = RxIdle; else rx_state_d = RxStop;
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  // Receiver counters, shift register and byte/framing-error pulses.
  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    rx_period_d = rx_period_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_valid_d  = 1'b0;
    rx_ferr_d   = 1'b0;
    if (!prog_i) begin
      rx_cnt_d = '0;
      rx_bit_d = 3'd0;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          rx_cnt_d = '0;
          if (rx_fall_s) begin
            rx_period_d = (clks_per_bit_i < MinPeriod) ? MinPeriod : clks_per_bit_i;
          end else begin
            rx_period_d = rx_period_q;
          end
        end
        RxStart: begin
          if (rx_half_s) begin
            rx_cnt_d = '0;
            rx_bit_d = 3'd0;
          end else begin
            rx_cnt_d = rx_cnt_q + CntWidth'(1'b1);
          end
        end
        RxData: begin
          if (rx_full_s) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + CntWidth'(1'b1);
          end
        end
        RxStop: begin
          if (rx_full_s) begin
            rx_cnt_d = '0;
            if (rx_sync_q) rx_valid_d = 1'b1; else rx_ferr_d = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + CntWidth'(1'b1);
          end
        end
        default: rx_cnt_d = '0;
      endcase
    end
  end

  // ---------------- Frame FSM ----------------
  typedef enum logic [2:0] {
    StIdle, StTarget, StAddrLo, StAddrHi, StLenLo, StLenHi, StData, StCsum
  } st_e;
  st_e                   state_q, state_d;
  logic [TgtWidth-1:0]   tgt_q, tgt_d;
  logic [7:0]            lo_q, lo_d;        // low byte waiting for its high byte
  logic [AddrWidth-1:0]  cur_addr_q, cur_addr_d;
  logic [15:0]           count_q, count_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [DataWidth-1:0]  word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [NumTargets-1:0] we_q, we_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic                  prog_rst_q, prog_rst_d, done_q, done_d, err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  tgt_ok_s, word_last_s, mid_frame_s;
  logic [15:0]           pair_s;
  logic [DataWidth-1:0]  word_asm_s;

  assign tgt_ok_s    = (rx_shift_q < NumTgtByte);
  assign word_last_s = (idx_q == LastIdx);
  assign mid_frame_s = (state_q != StIdle) && (state_q != StTarget);
  assign pair_s      = {rx_shift_q, lo_q};
  // New byte enters at the top so the first byte of a word ends up in the LSBs.
  assign word_asm_s  = (word_q >> ByteBits) | (DataWidth'(rx_shift_q) << (DataWidth - ByteBits));

  // Frame state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tgt_q      <= '0;
      lo_q       <= 8'h00;
      cur_addr_q <= '0;
      count_q    <= 16'd0;
      idx_q      <= '0;
      word_q     <= '0;
      csum_q     <= 8'h00;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      prog_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      lo_q       <= lo_d;
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      prog_rst_q <= prog_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Frame next state: abort beats framing error beats byte handling.
  always_comb begin
    state_d = state_q;
    if (!prog_i) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      state_d = StTarget;
    end else if (rx_ferr_q) begin
      state_d = StTarget;
    end else if (rx_valid_q) begin
      case (state_q)
        StTarget: if (tgt_ok_s) state_d = StAddrLo; else state_d = StTarget;
        StAddrLo: state_d = StAddrHi;
        StAddrHi: state_d = StLenLo;
        StLenLo:  state_d = StLenHi;
        StLenHi:  if (pair_s == 16'd0) state_d = StCsum; else state_d = StData;
        StData:   if (word_last_s && (count_q == 16'd1)) state_d = StCsum;
                  else state_d = StData;
        StCsum:   state_d = StTarget;
        default:  state_d = StIdle;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame datapath and registered outputs.
  always_comb begin
    tgt_d      = tgt_q;
    lo_d       = lo_q;
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    we_d       = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    prog_rst_d = (state_d == StIdle);
    if (!prog_i) begin
      if (mid_frame_s) begin
        err_d      = 1'b1;
        err_code_d = ErrAbort;
      end else begin
        err_d = err_q;
      end
    end else if (state_q == StIdle) begin
      idx_d = '0;
    end else if (rx_ferr_q) begin
      err_d      = 1'b1;
      err_code_d = ErrFraming;
    end else if (rx_valid_q) begin
      case (state_q)
        StTarget: begin
          if (tgt_ok_s) begin
            tgt_d  = TgtWidth'(rx_shift_q);
            err_d  = 1'b0;
            csum_d = 8'h00;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrTarget;
          end
        end
        StAddrLo: lo_d = rx_shift_q;
        StAddrHi: cur_addr_d = AddrWidth'(pair_s);
        StLenLo:  lo_d = rx_shift_q;
        StLenHi: begin
          count_d = pair_s;
          idx_d   = '0;
        end
        StData: begin
          csum_d = csum_next(csum_q, rx_shift_q);
          word_d = word_asm_s;
          if (word_last_s) begin
            we_d[tgt_q] = 1'b1;
            addr_d      = cur_addr_q;
            wdata_d     = word_asm_s;
            cur_addr_d  = cur_addr_q + AddrWidth'(1'b1);
            count_d     = count_q - 16'd1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IdxWidth'(1'b1);
          end
        end
        StCsum: begin
          if (rx_shift_q == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrCsum;
          end
        end
        default: done_d = 1'b0;
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  assign wr_bus.we    = we_q;
  assign wr_bus.addr  = addr_q;
  assign wr_bus.wdata = wdata_q;
  assign prog_rst_no  = prog_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: serialises UART frames, predicts writes and
// done pulses into a scoreboard queue, and a negedge monitor pops and compares
// every strobe the DUT presents.
module tb_prog_loader;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NT = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, prog, rx;
  logic [CW-1:0] cpb;
  logic          prog_rst_n, done, err;
  logic [1:0]    err_code;

  prog_loader_if #(.DataWidth(DW), .AddrWidth(AW), .NumTargets(NT)) bus();

  prog_loader #(.DataWidth(DW), .AddrWidth(AW), .NumTargets(NT), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .prog_i(prog), .clks_per_bit_i(cpb), .rx_i(rx),
    .wr_bus(bus), .prog_rst_no(prog_rst_n), .done_o(done), .err_o(err),
    .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [NT-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  bit            err_exp = 1'b0;
  logic [1:0]    code_exp = 2'd0;
  logic [DW-1:0] frame_words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe or done pulse must match the queue head.
  always @(negedge clk) begin
    if (mon_en && ((bus.we != '0) || done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got we=%b addr=%h data=%h done=%b expected nothing",
                 bus.we, bus.addr, bus.wdata, done);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done ? !(done && bus.we == '0)
                          : !(!done && bus.we == mon_e.we && bus.addr == mon_e.addr &&
                              bus.wdata == mon_e.data)) begin
          errors++;
          $display("FAIL event: got we=%b addr=%h data=%h done=%b expected we=%b addr=%h data=%h done=%b",
                   bus.we, bus.addr, bus.wdata, done, mon_e.we, mon_e.addr, mon_e.data, mon_e.is_done);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    int p;
    p = (cpb < 16'd4) ? 4 : int'(cpb);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Wait (bounded) for the scoreboard to drain, then check status outputs.
  task automatic settle_check(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    chk({tag, " drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, " err_o"}, 64'(err), 64'(err_exp));
    chk({tag, " err_code_o"}, 64'(err_code), 64'(code_exp));
    chk({tag, " prog_rst_no"}, 64'(prog_rst_n), prog ? 64'd0 : 64'd1);
  endtask

  // Reference model: frame bytes, expected writes and outcome from frame_words.
  task automatic run_frame(input string tag, input logic [7:0] tgt, input logic [15:0] base,
                           input bit corrupt);
    logic [7:0] bytes[$];
    logic [7:0] x;
    exp_t       e;
    int         n;
    n = frame_words.size();
    x = 8'h00;
    bytes = {tgt, base[7:0], base[15:8], 8'(n), 8'(n >> 8)};
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < DW / 8; b++) begin
        bytes.push_back(frame_words[i][8*b +: 8]);
        x = x ^ frame_words[i][8*b +: 8];
      end
      e.is_done = 1'b0;
      e.we      = NT'(1) << tgt;
      e.addr    = AW'(int'(base) + i);
      e.data    = frame_words[i];
      exp_q.push_back(e);
    end
    bytes.push_back(corrupt ? (x ^ 8'h01) : x);
    if (corrupt) begin
      err_exp  = 1'b1;
      code_exp = 2'd2;
    end else begin
      e.is_done = 1'b1;
      e.we      = '0;
      e.addr    = '0;
      e.data    = '0;
      exp_q.push_back(e);
      err_exp = 1'b0;
    end
    foreach (bytes[k]) send_byte(bytes[k], 1'b1);
    settle_check(tag);
  endtask

  task automatic bad_target(input string tag, input logic [7:0] tgt);
    send_byte(tgt, 1'b1);
    err_exp  = 1'b1;
    code_exp = 2'd1;
    settle_check(tag);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    rst_n = 1'b1;
    prog  = 1'b0;
    rx    = 1'b1;
    cpb   = 16'd8;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset we", 64'(bus.we), 64'd0);
    chk("reset addr", 64'(bus.addr), 64'd0);
    chk("reset wdata", 64'(bus.wdata), 64'd0);
    chk("reset prog_rst_no", 64'(prog_rst_n), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset err_code", 64'(err_code), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle prog_rst_no", 64'(prog_rst_n), 64'd1);
    prog = 1'b1;
    repeat (3) @(negedge clk);
    chk("prog entry prog_rst_no", 64'(prog_rst_n), 64'd0);

    // Directed frame and its checksum-corrupted twin.
    frame_words = {32'h11223344, 32'h55667788};
    run_frame("t1_good", 8'h00, 16'h0010, 1'b0);
    run_frame("t2_badcsum", 8'h00, 16'h0010, 1'b1);

    // Bad target, then a good frame to target 1 clears the error.
    bad_target("t3_badtgt", 8'h02);
    frame_words = {32'hCAFEF00D};
    run_frame("t3_tgt1", 8'h01, 16'h0042, 1'b0);

    // Framing error on the ADDR_HI byte, then a valid frame.
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b0);
    err_exp  = 1'b1;
    code_exp = 2'd0;
    settle_check("t4_framing");
    frame_words = {32'h0BADBEEF};
    run_frame("t4_recover", 8'h00, 16'h0020, 1'b0);

    // Abort after three bytes of a word.
    send_byte(8'h00, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    prog = 1'b0;
    chk("t5 prog_rst_no before edge", 64'(prog_rst_n), 64'd0);
    @(negedge clk);
    chk("t5 prog_rst_no after edge", 64'(prog_rst_n), 64'd1);
    err_exp  = 1'b1;
    code_exp = 2'd3;
    settle_check("t5_abort");
    prog = 1'b1;
    repeat (3) @(negedge clk);

    // Address wrap, zero-length frame, start-bit glitch.
    frame_words = {32'h01020304, 32'hA5A55A5A};
    run_frame("t6_wrap", 8'h00, 16'h0FFF, 1'b0);
    frame_words = {};
    run_frame("t6_count0", 8'h01, 16'h0123, 1'b0);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    settle_check("t6_glitch");

    // Leaving programming mode from TARGET raises no error.
    prog = 1'b0;
    repeat (2) @(negedge clk);
    chk("target exit prog_rst_no", 64'(prog_rst_n), 64'd1);
    chk("target exit err", 64'(err), 64'd0);
    prog = 1'b1;
    repeat (3) @(negedge clk);

    // Bit period below the minimum is clamped to 4.
    cpb = 16'd2;
    frame_words = {32'h89ABCDEF};
    run_frame("clamp", 8'h01, 16'h0555, 1'b0);

    // Randomised frames.
    for (int it = 0; it < 12; it++) begin
      cpb = 16'($urandom_range(3, 12));
      if ($urandom_range(0, 5) == 0) begin
        bad_target("rand_badtgt", 8'($urandom_range(2, 255)));
      end else begin
        n = $urandom_range(0, 3);
        frame_words = {};
        for (int w = 0; w < n; w++) frame_words.push_back($urandom);
        run_frame("rand_frame", 8'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised successor to the single-target UART ICCM programmer.
- Integrates a UART 8N1 receiver with a framed loader FSM.
- Writes words of configurable width into any of NumTargets memories (ICCM, DCCM, …) at a host-given base address, verified by a per-frame XOR checksum.
- Holds the core in reset while programming mode is active; sits beside the reset manager, and its write ports drive the memory adapters' controller-write interfaces.

Parameters:
- DataWidth, 32: word width in bits; multiple of 8, range 8..64.
- AddrWidth, 12: word-address width per target.
- NumTargets, 2: number of writable memories; range 1..8.
- CntWidth, 16: width of clks_per_bit_i.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- prog_i  input  1  programming-mode level.
- clks_per_bit_i  input  CntWidth  UART bit period in clk_i cycles.
- rx_i  input  1  UART serial in, idle high, asynchronous.
- we_o  output  NumTargets  one-hot, single-cycle write strobe per target.
- addr_o  output  AddrWidth  word address.
- wdata_o  output  DataWidth  write data.
- prog_rst_no  output  1  core reset, low while programming.
- done_o  output  1  one-cycle pulse on checksum-good frame end.
- err_o  output  1  sticky error flag.
- err_code_o  output  2  0 framing, 1 bad target, 2 checksum, 3 abort.

Behaviour:
- Reset values: we_o=0, addr_o=0, wdata_o=0, prog_rst_no=1, done_o=0, err_o=0, err_code_o=0. FSM in IDLE; rx synchroniser flops reset to 1.

UART receiver:
- rx_i passes through a 2-flop synchroniser.
- A falling edge starts a byte. clks_per_bit_i is latched at this point; values <4 are clamped to 4.
- Start bit is re-checked at half period; if high, the edge is a glitch and no byte is produced.
- 8 data bits (LSB first) are sampled at mid-bit, then the stop bit.
- Stop bit = 1: emit byte_valid for one cycle.
- Stop bit = 0: framing error (code 0), no byte_valid; receiver waits for rx high before re-arming.
- Receiver runs only while prog_i=1; otherwise it is held idle.

Frame FSM:
- States: IDLE, TARGET, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CSUM.
- IDLE: prog_rst_no=1. When prog_i=1: prog_rst_no=0 next cycle, go to TARGET.
- TARGET: byte < NumTargets latches the target, clears err_o, goes to ADDR_LO. Otherwise err (code 1) and stay in TARGET.
- ADDR_LO/ADDR_HI: 16-bit little-endian base word address; bits above AddrWidth are ignored.
- LEN_LO/LEN_HI: 16-bit little-endian word count. Count 0 goes directly to CSUM; otherwise go to DATA.
- DATA: bytes assemble little-endian into a DataWidth/8-byte word.
  - On the last byte of a word, the next cycle drives we_o[target]=1, addr_o=current address, wdata_o=word.
  - Address then increments modulo 2^AddrWidth (wraps); remaining count decrements.
  - Count reaching 0 goes to CSUM.
- Checksum: XOR of all DATA bytes, cleared on entry to ADDR_LO.
- CSUM: match pulses done_o; mismatch sets err (code 2). Writes already issued are not undone. Either way, return to TARGET, so multiple frames are allowed per session.
- Framing error in any non-IDLE state: err code 0, frame discarded, return to TARGET.
- prog_i falling in any state: return to IDLE and set prog_rst_no=1 next cycle.
  - Mid-frame (ADDR_LO..CSUM): partial word is dropped, err code 3.
  - In TARGET: no error.
- Error priority: err_code_o holds the most recent error; err_o stays 1 until the next accepted target byte or reset.
- addr_o and wdata_o hold their last written values between strobes; we_o and done_o are never asserted in the same cycle.

Test Plan:
1. clks_per_bit=8; frame 00 10 00 02 00 44 33 22 11 88 77 66 55 88 -> we_o=01 with addr 0x010/0x11223344, then 0x011/0x55667788; done_o pulses once; err_o=0; prog_rst_no=0 throughout.
2. Same frame with checksum byte 0x89 -> both writes occur; no done_o; err_o=1, err_code_o=2.
3. Target byte 0x02 (NumTargets=2) -> no writes, err_code_o=1. Following frame to target 01 clears err_o and strobes we_o=10.
4. Stop bit driven 0 on the ADDR_HI byte -> err_code_o=0, no writes; FSM back in TARGET; next valid frame completes.
5. prog_i dropped after 3 of 4 bytes of a word -> no we_o, err_code_o=3, prog_rst_no=1 one cycle later.
6. Base 0x0FFF, count 2 -> writes at 0xFFF then 0x000. Count-0 frame with checksum 0x00 -> done_o, no writes. A 2-cycle low glitch on rx_i -> no byte accepted.
